// File: rtl/mult.sv
// mult: sequential radix-2 Booth signed multiplier, one step per clock, restarted by reset
module mult #(
  parameter int NUM_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_BITS-1:0]     multiplicando,
  input  logic [NUM_BITS-1:0]     multiplicador,
  output logic [2*NUM_BITS-1:0]   resultado,
  output logic                    Fin
);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [1:0] LOAD = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0]            state;
  logic [NUM_BITS:0]     m, a, a_next;
  logic [NUM_BITS-1:0]   q;
  logic                  q_1;
  logic [CW-1:0]         count;
  logic [2*NUM_BITS+1:0] shifted;
  // Booth add/subtract, then arithmetic shift of {A,Q,Q_1} (old Q_1 falls off)
  always_comb begin
    a_next  = ({q[0], q_1} == 2'b01) ? a + m : ({q[0], q_1} == 2'b10) ? a - m : a;
    shifted = {a_next[NUM_BITS], a_next, q};
  end
  // Load operands, run NUM_BITS Booth steps, then hold the product until reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      resultado <= '0;
      Fin       <= 1'b0;
      m         <= '0;
      a         <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      count     <= '0;
    end else if (state == LOAD) begin
      m     <= {multiplicando[NUM_BITS-1], multiplicando};
      q     <= multiplicador;
      a     <= '0;
      q_1   <= 1'b0;
      count <= CW'(NUM_BITS);
      state <= CALC;
    end else if (state == CALC) begin
      a     <= shifted[2*NUM_BITS+1:NUM_BITS+1];
      q     <= shifted[NUM_BITS:1];
      q_1   <= shifted[0];
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        resultado <= shifted[2*NUM_BITS:1];
        Fin       <= 1'b1;
        state     <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_mult.sv
// tb_mult: directed and exhaustive checks of the Booth multiplier for NUM_BITS=3
module tb_mult;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mcand = '0;
  logic [2:0] mplier = '0;
  logic [5:0] res;
  logic       fin;
  int         total = 0;
  int         bad = 0;

  mult #(.NUM_BITS(3)) dut (
    .clk(clk),
    .reset(reset),
    .multiplicando(mcand),
    .multiplicador(mplier),
    .resultado(res),
    .Fin(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // one full operation; scramble alters the operands every cycle after the load edge
  task automatic run(input logic [2:0] a, input logic [2:0] b, input logic [5:0] exp,
                     input string tag, input bit scramble);
    logic prev;
    int   rises;
    mcand = a;
    mplier = b;
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_rst"}, {25'd0, fin, res}, 32'd0);
    reset = 1'b1;
    prev = fin;
    rises = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (fin && !prev) rises++;
      prev = fin;
      if (scramble) begin
        mcand = ~mcand;
        mplier = mplier + 3'd1;
      end
      if (i < 4) chk({tag, "_busy"}, {25'd0, fin, res}, 32'd0);
    end
    chk({tag, "_fin"}, {31'd0, fin}, 32'd1);
    chk({tag, "_res"}, {26'd0, res}, {26'd0, exp});
    @(negedge clk);
    if (fin && !prev) rises++;
    chk({tag, "_hold"}, {25'd0, fin, res}, {25'd0, 1'b1, exp});
    chk({tag, "_rises"}, rises, 1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {25'd0, fin, res}, 32'd0);

    run(3'b100, 3'b100, 6'b010000, "m4xm4", 1'b0);
    run(3'b011, 3'b100, 6'b110100, "3xm4", 1'b0);
    run(3'b100, 3'b011, 6'b110100, "m4x3", 1'b0);
    run(3'b011, 3'b011, 6'b001001, "3x3", 1'b0);
    run(3'b111, 3'b111, 6'b000001, "m1xm1", 1'b0);
    run(3'b000, 3'b101, 6'b000000, "0xm3", 1'b0);
    run(3'b010, 3'b111, 6'b111110, "2xm1", 1'b0);

    for (int x = -4; x <= 3; x++)
      for (int y = -4; y <= 3; y++)
        run(x[2:0], y[2:0], 6'(x * y), $sformatf("ex_%0d_%0d", x, y), 1'b0);

    mcand = 3'b011;
    mplier = 3'b011;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mcand = 3'b100;
    mplier = 3'b011;
    @(negedge clk);
    chk("midop_abort", {25'd0, fin, res}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midop_busy", {25'd0, fin, res}, 32'd0);
    @(negedge clk);
    chk("midop_restart", {25'd0, fin, res}, {25'd0, 1'b1, 6'b110100});

    run(3'b010, 3'b111, 6'b111110, "scramble", 1'b1);
    mcand = 3'b011;
    mplier = 3'b011;
    repeat (3) @(negedge clk);
    chk("done_hold", {25'd0, fin, res}, {25'd0, 1'b1, 6'b111110});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult.md
Name: mult

Overview:
- Sequential signed multiplier using radix-2 Booth's algorithm.
- Multiplies two NUM_BITS two's-complement operands into a 2*NUM_BITS two's-complement product, one Booth step per clock.
- Each operation starts when reset is released. Completion is flagged on Fin.
- Used as a standalone arithmetic unit; the controller restarts it by pulsing reset between operations.

Parameters:
NUM_BITS, 3, width of each signed operand; product width is 2*NUM_BITS; must be >= 2.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous active-low reset; also acts as the start control (operation begins after it is released).
multiplicando  input  NUM_BITS  signed multiplicand M; sampled once, at the load edge.
multiplicador  input  NUM_BITS  signed multiplier Q; sampled once, at the load edge.
resultado  output  2*NUM_BITS  signed product; registered.
Fin  output  1  done flag; registered; high while resultado is valid.

Behaviour:
- Reset: one clock, synchronous, active-low. At any rising clk edge with reset=0:
  - state <= LOAD; resultado <= 0; Fin <= 0.
  - internal A, Q, Q_1 and count cleared.
  - Reset has priority in every state, including mid-operation; a partial computation is discarded.
- Internal registers:
  - M: NUM_BITS+1 bits, sign-extended multiplicand. The extra bit prevents overflow when the multiplicand is the most negative value, e.g. -4 for N=3.
  - A: NUM_BITS+1 bits.
  - Q: NUM_BITS bits.
  - Q_1: 1 bit.
  - count: ceil(log2(NUM_BITS+1)) bits.
- State machine, states LOAD, CALC, DONE:
  - LOAD, first edge with reset=1: M <= sext(multiplicando); Q <= multiplicador; A <= 0; Q_1 <= 0; count <= NUM_BITS; go to CALC. Fin stays 0.
  - CALC, each edge performs one Booth step:
    - Select on {Q[0],Q_1}: 00/11 no change; 01 A' = A + M; 10 A' = A - M. Arithmetic is in NUM_BITS+1 bits, modulo.
    - Then arithmetic right shift of {A',Q,Q_1} by one; the A MSB is replicated.
    - count decrements by 1.
    - On the step where count goes 1->0: resultado <= bits [2N-1:0] of the shifted {A,Q} (low NUM_BITS of A concatenated with Q); Fin <= 1; go to DONE.
  - DONE: hold resultado and Fin=1 indefinitely. Input changes are ignored. No automatic restart; only reset leaves DONE.
- Latency: Fin rises NUM_BITS+1 rising edges after the first edge with reset=1 (1 load + N steps). That is 4 cycles for N=3.
- Operands need only be stable at the load edge; later changes do not affect the running operation.
- resultado holds 0 from reset until DONE; it never shows partial values.
- Product rules:
  - Exact for all operand pairs in [-2^(N-1), 2^(N-1)-1].
  - The extreme case (-2^(N-1))*(-2^(N-1)) = 2^(2N-2) fits in 2N signed bits and must be correct.
- Fin is a level, not a pulse. It rises exactly once per operation, which gives a clean rising edge per result.
- Back-to-back operations: change the operands, pulse reset low for at least one clock edge, release. The new result appears N+1 cycles later.

Test Plan:
- N=3, M=-4, Q=-4, reset pulse then release -> Fin rises after 4 edges; resultado=010000 (16); stays 0 before Fin.
- N=3, M=3, Q=-4 -> resultado=110100 (-12); M=-4, Q=3 -> 110100; M=3, Q=3 -> 001001 (9).
- N=3, M=-1, Q=-1 -> 000001; M=0, Q=-3 -> 000000; M=2, Q=-1 -> 111110 (-2).
- Exhaustive: all 64 pairs in [-4..3]x[-4..3], reset pulse between each -> resultado equals the signed product every time; exactly one Fin rising edge per operation.
- Reset mid-operation: assert reset after 2 CALC edges -> next edge gives Fin=0, resultado=0. After release, the full N+1-cycle operation restarts with the currently presented operands.
- Input change during CALC and in DONE: alter the operands after the load edge -> result reflects the loaded values; DONE outputs unchanged until reset.
